ex_ext_stage: RTL and testbench
===============================

Name: ex_ext_stage

Overview:
- Registered result-extension stage at the EX/MEM boundary of the RV64 pipeline.
- Sign- or zero-extends the writeback value from a selectable source width (8/16/32 bits, or pass-through).
- Buffers results in a DEPTH-entry FIFO with valid/ready handshake, so downstream stalls do not drop instructions.
- Propagates the staller flag only for valid entries and counts downstream stall cycles for performance monitoring.

Parameters:
- XLEN, 64, datapath width; must be >= 32.
- DEPTH, 2, FIFO entries; power of 2, >= 2.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  synchronous reset, active low.
- i_flush  input  1  discard all buffered entries.
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  stage can accept an entry this cycle.
- i_data  input  XLEN  raw writeback value.
- i_ext_mode  input  3  extension mode (see Behaviour).
- i_rd  input  5  destination register index.
- i_wr_en  input  1  register-file write enable.
- i_is_staller  input  1  entry is a staller (e.g. load-use producer).
- i_stall  input  1  downstream stall; head entry is held.
- o_valid  output  1  head entry valid.
- o_data  output  XLEN  extended value of the head entry.
- o_rd  output  5  head destination index.
- o_wr_en  output  1  head write enable.
- o_staller  output  1  head staller flag, gated by o_valid.
- o_stall_cnt  output  CNT_W  saturating count of stalled-valid cycles.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - occupancy, read pointer and write pointer go to 0.
  - o_stall_cnt goes to 0; o_valid=0; o_ready=1.
  - Reset overrides flush, push and pop in the same cycle, including when it arrives mid-stall with the FIFO full.
- Extension is combinational on the input; the result is stored, never recomputed at the output:
  - 000: pass-through.
  - 001: sign-extend bit 31.
  - 010: sign-extend bit 15.
  - 011: sign-extend bit 7.
  - 101: zero-extend from 32 bits.
  - 110: zero-extend from 16 bits.
  - 111: zero-extend from 8 bits.
  - 100 (reserved): pass-through.
- Handshake:
  - push = i_valid & o_ready.
  - pop = o_valid & ~i_stall.
  - o_ready = (count != DEPTH), derived from registered state only, with no combinational path from i_stall.
- Push and pop in the same cycle: count unchanged; both pointers advance and wrap modulo DEPTH.
- Latency: an entry pushed into an empty FIFO appears on the outputs on the next rising edge (1 cycle). There is no bypass.
- o_valid = (count != 0).
- When empty, o_data, o_rd, o_wr_en and o_staller are driven to 0.
- o_staller = o_valid & head.is_staller. The flag is never asserted for an invalid slot.
- Full FIFO: o_ready=0. i_valid is ignored, so no overwrite or loss occurs. When a pop occurs, o_ready rises on the following cycle.
- Flush (i_flush=1, i_rst_n=1):
  - next cycle count=0 and pointers=0.
  - a concurrent push and a concurrent pop are both discarded.
  - o_stall_cnt is not cleared.
- Stall counter: increments by 1 on each cycle with o_valid & i_stall. It saturates at 2^CNT_W-1 and does not wrap.
- i_stall with an empty FIFO has no effect and is not counted.
- Entry order is strict FIFO.

Test Plan:
- Extension modes: i_data=0x00000000_8000F080, push modes 001/010/011/101/110/111/100 back to back with i_stall=0. Required o_data one cycle after each push, in order:
  - 0xFFFFFFFF_8000F080
  - 0xFFFFFFFF_FFFFF080
  - 0xFFFFFFFF_FFFFFF80
  - 0x00000000_8000F080
  - 0x00000000_0000F080
  - 0x00000000_00000080
  - 0x00000000_8000F080
- Fill and stall: hold i_stall=1 and push A,B,C with i_valid=1 every cycle.
  - Required: A and B accepted, o_ready=0 after the second push, C held upstream.
  - Release i_stall: outputs A, B, then C (accepted once o_ready returns), with no loss or duplication.
- Staller gating: push one entry with i_is_staller=1, then idle.
  - Required: o_staller=1 for exactly the cycles with o_valid=1.
  - Required: o_staller=0 once empty, even with i_is_staller held at 1 and i_valid=0.
- Flush versus push: FIFO holds 2 entries; assert i_flush and i_valid together.
  - Required next cycle: o_valid=0, o_ready=1, and the pushed entry is not present.
- Stall counter: CNT_W=4, one valid entry, i_stall=1 for 20 cycles.
  - Required: o_stall_cnt=15, held (no wrap).
  - Required: the count is unchanged by a flush and returns to 0 only on i_rst_n=0.
- Reset mid-operation: FIFO full with i_stall=1; assert i_rst_n=0 together with i_valid=1.
  - Required next cycle: o_valid=0, o_ready=1, o_stall_cnt=0.
  - Required: the concurrent push is not accepted.

Source files
------------

// File: rtl/ex_ext_stage.sv
// Result-extension stage at the EX/MEM boundary: sign/zero-extends the
// writeback value and buffers it in a small FIFO with stall accounting.
module ex_ext_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_data,
    input  logic [2:0]       i_ext_mode,
    input  logic [4:0]       i_rd,
    input  logic             i_wr_en,
    input  logic             i_is_staller,
    input  logic             i_stall,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_data,
    output logic [4:0]       o_rd,
    output logic             o_wr_en,
    output logic             o_staller,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            wr_en;
        logic            staller;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_e;
    entry_t           head;
    logic [XLEN-1:0]  ext;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic [CNT_W-1:0] stall_cnt;
    logic             push;
    logic             pop;

    // Extension happens before storage so the output path is a plain read.
    always_comb begin
        ext = i_data;
        unique case (i_ext_mode)
            3'b001:  ext = {{(XLEN-32){i_data[31]}}, i_data[31:0]};
            3'b010:  ext = {{(XLEN-16){i_data[15]}}, i_data[15:0]};
            3'b011:  ext = {{(XLEN-8){i_data[7]}}, i_data[7:0]};
            3'b101:  ext = {{(XLEN-32){1'b0}}, i_data[31:0]};
            3'b110:  ext = {{(XLEN-16){1'b0}}, i_data[15:0]};
            3'b111:  ext = {{(XLEN-8){1'b0}}, i_data[7:0]};
            default: ext = i_data;
        endcase
    end

    assign in_e    = '{data: ext, rd: i_rd, wr_en: i_wr_en,
                       staller: i_is_staller};
    assign o_ready = (count != FULL);
    assign o_valid = (count != '0);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & ~i_stall;
    assign head    = mem[rd_ptr];

    assign o_data      = o_valid ? head.data : '0;
    assign o_rd        = o_valid ? head.rd : '0;
    assign o_wr_en     = o_valid & head.wr_en;
    assign o_staller   = o_valid & head.staller;
    assign o_stall_cnt = stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && push) begin
            mem[wr_ptr] <= in_e;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (o_valid && i_stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            // Flush drops a concurrent push and pop but keeps the perf count.
            if (i_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_ext_stage.sv
// Scoreboard bench for ex_ext_stage: driver queues expected entries,
// a negedge monitor pops and compares on every DUT output pop.
module tb_ex_ext_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             valid;
    logic             ready;
    logic [XLEN-1:0]  data;
    logic [2:0]       mode;
    logic [4:0]       rd;
    logic             wr_en;
    logic             is_staller;
    logic             stall;
    logic             o_valid;
    logic [XLEN-1:0]  o_data;
    logic [4:0]       o_rd;
    logic             o_wr_en;
    logic             o_staller;
    logic [CNT_W-1:0] o_stall_cnt;

    logic [63:0] exp_data;
    logic [71:0] sb [$];
    int          errors = 0;
    int          checks = 0;

    logic [2:0]  mode_tbl [7] = '{3'b001, 3'b010, 3'b011, 3'b101,
                                  3'b110, 3'b111, 3'b100};
    logic [63:0] ext_tbl  [7] = '{64'hFFFFFFFF_8000F080,
                                  64'hFFFFFFFF_FFFFF080,
                                  64'hFFFFFFFF_FFFFFF80,
                                  64'h00000000_8000F080,
                                  64'h00000000_0000F080,
                                  64'h00000000_00000080,
                                  64'h00000000_8000F080};

    always #5 clk = ~clk;

    ex_ext_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_data       (data),
        .i_ext_mode   (mode),
        .i_rd         (rd),
        .i_wr_en      (wr_en),
        .i_is_staller (is_staller),
        .i_stall      (stall),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_rd         (o_rd),
        .o_wr_en      (o_wr_en),
        .o_staller    (o_staller),
        .o_stall_cnt  (o_stall_cnt)
    );

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop on DUT pop, then track pushes / discards.
    always @(negedge clk) begin
        if (rst_n && !flush && o_valid && !stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected none",
                         o_data);
            end else begin
                chk("out", {o_data, o_rd, o_wr_en, o_staller},
                    sb.pop_front());
            end
        end
        if (!rst_n || flush) begin
            sb.delete();
        end else if (valid && ready) begin
            sb.push_back({exp_data, rd, wr_en, is_staller});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] d, input logic [2:0] m,
                       input logic [4:0] r, input logic s,
                       input logic [63:0] e);
        valid      = 1'b1;
        data       = d;
        mode       = m;
        rd         = r;
        wr_en      = 1'b1;
        is_staller = s;
        exp_data   = e;
    endtask

    task automatic drain();
        int n = 0;
        while ((o_valid || sb.size() != 0) && n < 50) begin
            step();
            n++;
        end
        chk("drain", 72'(sb.size()), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; data = '0;
        mode = '0; rd = '0; wr_en = 1'b0; is_staller = 1'b0;
        stall = 1'b0; exp_data = '0;
        step(); step();
        chk("rst_valid", 72'(o_valid), 72'd0);
        chk("rst_ready", 72'(ready), 72'd1);
        chk("rst_cnt", 72'(o_stall_cnt), 72'd0);
        rst_n = 1'b1;
        step();

        // extension modes, back to back
        for (int i = 0; i < 7; i++) begin
            put(64'h00000000_8000F080, mode_tbl[i], 5'(i + 1), 1'b0,
                ext_tbl[i]);
            step();
            chk("latency", {o_valid, o_data}, {8'h01, ext_tbl[i]});
        end
        valid = 1'b0;
        drain();

        // fill while stalled, C held upstream
        stall = 1'b1;
        put(64'hA, 3'b000, 5'd10, 1'b0, 64'hA);
        step();
        put(64'hB, 3'b000, 5'd11, 1'b0, 64'hB);
        step();
        chk("full_ready", 72'(ready), 72'd0);
        put(64'hC, 3'b000, 5'd12, 1'b0, 64'hC);
        step(); step();
        chk("head_held", {ready, o_data}, {8'h00, 64'hA});
        stall = 1'b0;
        for (int n = 0; n < 10 && !ready; n++) step();
        step();
        valid = 1'b0;
        drain();

        // staller gating
        put(64'h5, 3'b000, 5'd5, 1'b1, 64'h5);
        step();
        valid = 1'b0;
        chk("staller_on", {o_valid, o_staller}, 72'h3);
        step();
        chk("staller_off", {o_valid, o_staller}, 72'h0);
        step();
        chk("staller_idle", 72'(o_staller), 72'd0);

        // flush versus push, full then single entry
        stall = 1'b1;
        put(64'hD, 3'b000, 5'd13, 1'b0, 64'hD);
        step();
        put(64'hE, 3'b000, 5'd14, 1'b0, 64'hE);
        step();
        flush = 1'b1;
        put(64'hF, 3'b000, 5'd15, 1'b0, 64'hF);
        step();
        flush = 1'b0;
        valid = 1'b0;
        chk("flush_full", {o_valid, ready}, 72'h1);
        put(64'h11, 3'b000, 5'd16, 1'b0, 64'h11);
        step();
        valid = 1'b0;
        chk("one_entry", 72'(o_valid), 72'd1);
        flush = 1'b1;
        put(64'h12, 3'b000, 5'd17, 1'b0, 64'h12);
        step();
        flush = 1'b0;
        valid = 1'b0;
        stall = 1'b0;
        step(); step();
        chk("flush_push_gone", 72'(o_valid), 72'd0);

        // stall counter saturation
        rst_n = 1'b0;
        step();
        chk("cnt_reset", 72'(o_stall_cnt), 72'd0);
        rst_n = 1'b1;
        stall = 1'b1;
        put(64'h20, 3'b000, 5'd20, 1'b0, 64'h20);
        step();
        valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("cnt_5", 72'(o_stall_cnt), 72'd5);
        for (int i = 0; i < 15; i++) step();
        chk("cnt_sat", 72'(o_stall_cnt), 72'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt_flush", {o_valid, o_stall_cnt}, 72'h0F);
        step(); step(); step();
        chk("cnt_empty", 72'(o_stall_cnt), 72'd15);

        // reset while full and stalled
        put(64'h30, 3'b000, 5'd21, 1'b0, 64'h30);
        step();
        put(64'h31, 3'b000, 5'd22, 1'b0, 64'h31);
        step();
        chk("pre_rst_full", 72'(ready), 72'd0);
        rst_n = 1'b0;
        put(64'h32, 3'b000, 5'd23, 1'b0, 64'h32);
        step();
        rst_n = 1'b1;
        valid = 1'b0;
        chk("rst_mid", {o_valid, ready, o_stall_cnt}, 72'h10);
        stall = 1'b0;
        step(); step();
        chk("rst_push_gone", 72'(o_valid), 72'd0);

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
